// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: drives a wait-state capable imem handshake and a registered IF/ID slot
// with stall, flush and jump/branch redirect. Define IF_PERF_EN to add fetch/redirect counters.
module if_fetch_stage #(
    parameter int                     PC_WIDTH    = 10,
    parameter int                     INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0,
    parameter logic [PC_WIDTH-1:0]    PC_STEP     = PC_WIDTH'(4),
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   flush,
    input  logic                   branch_taken,
    input  logic [PC_WIDTH-1:0]    branch_address,
    input  logic                   jump,
    input  logic [PC_WIDTH-1:0]    jump_address,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_ready,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic                   if_valid,
    output logic [PC_WIDTH-1:0]    if_pc,
    output logic [PC_WIDTH-1:0]    if_pc_plus4,
    output logic [INSTR_WIDTH-1:0] if_instr
`ifdef IF_PERF_EN
    ,
    output logic [31:0]            perf_fetch_cnt,
    output logic [31:0]            perf_redirect_cnt
`endif
);

    localparam logic ST_FETCH = 1'b0;
    localparam logic ST_HOLD  = 1'b1;

    logic                   state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] hold_q, hold_d;
    logic                   valid_d;
    logic [PC_WIDTH-1:0]    slot_pc_d, slot_pc4_d;
    logic [INSTR_WIDTH-1:0] slot_instr_d;
    logic                   redirect;
    logic [PC_WIDTH-1:0]    target;
    logic [PC_WIDTH-1:0]    pc_seq;
    logic                   load_slot;
    logic [INSTR_WIDTH-1:0] load_word;

    assign redirect  = jump | branch_taken;
    assign target    = jump ? jump_address : branch_address;
    assign pc_seq    = pc_q + PC_STEP;
    assign imem_req  = (state_q == ST_FETCH);
    assign imem_addr = pc_q;

    // A redirect beats everything else, including stall; flush only kills the slot contents.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        hold_d       = hold_q;
        valid_d      = if_valid;
        slot_pc_d    = if_pc;
        slot_pc4_d   = if_pc_plus4;
        slot_instr_d = if_instr;
        load_slot    = 1'b0;
        load_word    = imem_rdata;

        if (redirect) begin
            pc_d         = target;
            state_d      = ST_FETCH;
            valid_d      = 1'b0;
            slot_instr_d = NOP_INSTR;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (imem_ready) begin
                        if (stall) begin
                            hold_d  = imem_rdata;
                            state_d = ST_HOLD;
                        end else begin
                            load_slot = 1'b1;
                        end
                    end else if (!stall) begin
                        valid_d      = 1'b0;
                        slot_instr_d = NOP_INSTR;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        load_slot = 1'b1;
                        load_word = hold_q;
                        state_d   = ST_FETCH;
                    end
                end
                default: state_d = ST_FETCH;
            endcase

            if (load_slot) begin
                pc_d         = pc_seq;
                valid_d      = 1'b1;
                slot_pc_d    = pc_q;
                slot_pc4_d   = pc_seq;
                slot_instr_d = load_word;
            end

            if (flush) begin
                valid_d      = 1'b0;
                slot_instr_d = NOP_INSTR;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_FETCH;
            pc_q        <= RESET_PC;
            hold_q      <= NOP_INSTR;
            if_valid    <= 1'b0;
            if_pc       <= '0;
            if_pc_plus4 <= '0;
            if_instr    <= NOP_INSTR;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            hold_q      <= hold_d;
            if_valid    <= valid_d;
            if_pc       <= slot_pc_d;
            if_pc_plus4 <= slot_pc4_d;
            if_instr    <= slot_instr_d;
        end
    end

`ifdef IF_PERF_EN
    // Only slot writes that survive a same-cycle flush count as fetched instructions.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetch_cnt    <= '0;
            perf_redirect_cnt <= '0;
        end else begin
            if (load_slot && !flush) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (redirect) begin
                perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
